data_ram_pipe: RTL
==================

# data_ram_pipe

Parametrised, pipelined data-memory simulation model with a valid/ready request channel, a valid/ready response channel, per-byte write enables and a configurable read latency of 1–4 cycles. It replaces the single-cycle synchronous DRAM model behind the LoadStoreUnit. Every accepted request returns exactly one in-order response, so the pipeline can stall on memory rather than depending on a fixed one-beat read. It is a behavioural model for simulation, not for synthesis.

## Interface
- DATA_W, 32: word width in bits; must be a multiple of 8.
- ADDR_W, 16: word-address width; depth is 2**ADDR_W words.
- READ_LAT, 2: request-accept to response-valid latency in cycles; legal range 1..4.
- MAX_OUT, READ_LAT+1: maximum outstanding requests, which is also the response buffer depth.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_addr  in  ADDR_W  word address.
- req_we  in  DATA_W/8  byte write enables; all-zero means read.
- req_wdata  in  DATA_W  write data, byte-lane aligned; merging is done upstream.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data.

## Operation
- Elaboration: READ_LAT outside 1..4 or DATA_W%8≠0 → $fatal.
- Memory array: zero-filled at time 0. Reset does not clear the array.
- Accept: req_valid && req_ready at a rising edge.
- Read accept: the word at req_addr is sampled at the accept edge.
- Write accept: the byte lanes with req_we[i]=1 are updated at the accept edge. Other lanes are unchanged. The response carries the pre-write word (read-before-write).
- Ordering:
  - A request accepted after a write to the same address observes the written data.
  - Responses are returned strictly in accept order.
- Data path: a READ_LAT-deep delay pipeline feeds an in-order response FIFO of MAX_OUT entries. The FIFO is fall-through, so an empty FIFO adds no cycle.
- Outstanding counter `out_cnt` (0..MAX_OUT):
  - +1 on request accept.
  - −1 on response handshake (rsp_valid && rsp_ready).
  - Both events in the same cycle → unchanged.
- req_ready = !rst && (out_cnt < MAX_OUT). It is driven from registered state only, with no combinational path from rsp_ready or req_valid.
- rsp_valid = FIFO non-empty. rsp_rdata = FIFO head. Both hold stable while rsp_valid && !rsp_ready.
- Full boundary: out_cnt==MAX_OUT → req_ready=0. req_ready rises in the cycle after the draining response handshake.
- Empty boundary: rsp_valid=0 and rsp_rdata keeps its last value; its value is don't-care to consumers.
- Logging:
  - One line per accept: `$time`, address, data, we, tagged [MEM W] or [MEM R].
  - Logging is gated by the DEBUG define.

## Timing
- Reset (asynchronous):
  - While rst=1: req_ready=0, rsp_valid=0, rsp_rdata=0, out_cnt=0, pipeline valid bits=0, FIFO empty.
  - req_ready=1 from the first cycle after rst falls.
- Reset mid-operation:
  - All in-flight and buffered responses are discarded.
  - Writes committed on edges before rst rose persist.
  - A request presented during reset is not accepted.
- Latency: request accepted at edge E → rsp_valid=1 and rsp_rdata valid immediately after edge E+READ_LAT−1, provided no older response is pending. READ_LAT=1 matches the legacy model, with data valid right after the accept edge.
- Throughput: one request per cycle sustained while rsp_ready=1.
- Backpressure: rsp_ready=0 for n cycles → at most MAX_OUT requests are accepted, and none are lost or duplicated.
- Simultaneous events: a response handshake and a request accept in the same cycle with out_cnt==MAX_OUT−1 → accepted. out_cnt stays MAX_OUT−1.

## Test plan
- Reset then idle:
  - Hold rst for 3 cycles, then release.
  - Required: rsp_valid=0 and rsp_rdata=0 throughout.
  - Required: req_ready=0 during reset, 1 in the first cycle after.
- Byte-write merge (READ_LAT=2):
  - Write 0x11223344 we=1111 at addr 0x0018, then 0x0000AA00 we=0010 at 0x0018, then read 0x0018.
  - Required responses, in order: 0x00000000, 0x11223344, 0x1122AA44.
  - Required: the read response is valid 1 cycle after its accept edge.
- Back-to-back read after write:
  - Write 0xDEADBEEF we=1111 to 0x001C at edge E; read 0x001C at E+1.
  - Required: the read returns 0xDEADBEEF, valid after edge E+READ_LAT.
- Backpressure:
  - READ_LAT=3, rsp_ready=0, req_valid held high for 10 cycles with reads of addr 0..9.
  - Required: exactly 4 accepted (addr 0..3) and req_ready=0 thereafter.
  - Then set rsp_ready=1. Required: responses for addr 0..9 in order, with no gaps beyond one cycle.
- Simultaneous drain/accept: with out_cnt=3 of 4, a response handshake and a request accept in the same cycle → out_cnt stays 3 and req_ready stays 1.
- Reset mid-flight:
  - Write 0xCAFEF00D to 0x0020, issue two reads, assert rst before they respond.
  - Required: no response appears after reset.
  - Required: a fresh read of 0x0020 returns 0xCAFEF00D.
- Parameter sweep: repeat scenarios 2 and 4 for READ_LAT=1,2,3,4 and DATA_W=32,64.

Source files
------------

// File: rtl/data_ram_pipe.sv
// rtl/data_ram_pipe.sv - pipelined data-memory model with valid/ready request and response channels
module data_ram_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 16,
    parameter int READ_LAT = 2,
    parameter int MAX_OUT  = READ_LAT + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_we,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata
);
    localparam int NB = DATA_W / 8;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $fatal(1, "data_ram_pipe: READ_LAT must be 1..4");
    end
    if (DATA_W % 8 != 0) begin : g_bad_width
        $fatal(1, "data_ram_pipe: DATA_W must be a multiple of 8");
    end

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [CW-1:0]     out_cnt;
    logic [READ_LAT-1:0] pipe_v;
    logic [DATA_W-1:0] pipe_d [READ_LAT];
    logic [DATA_W-1:0] fifo_d [MAX_OUT];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     fifo_cnt;
    logic [DATA_W-1:0] last_rdata;
    logic              accept, rsp_hs, push, pop, fifo_empty, tail_v;
    logic [DATA_W-1:0] tail_d;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req_ready  = !rst && (out_cnt < CW'(MAX_OUT));
    assign accept     = req_valid && req_ready;
    assign rsp_hs     = rsp_valid && rsp_ready;
    assign tail_v     = pipe_v[READ_LAT-1];
    assign tail_d     = pipe_d[READ_LAT-1];
    assign fifo_empty = (fifo_cnt == '0);
    // The pipeline tail bypasses an empty FIFO; it is only buffered when not taken at once.
    assign push       = tail_v && !(fifo_empty && rsp_ready);
    assign pop        = !fifo_empty && rsp_ready;

    always_comb begin
        rsp_valid = !fifo_empty || tail_v;
        rsp_rdata = last_rdata;
        if (!fifo_empty) begin
            rsp_rdata = fifo_d[rd_ptr];
        end else if (tail_v) begin
            rsp_rdata = tail_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v     <= '0;
            for (int i = 0; i < READ_LAT; i++) pipe_d[i] <= '0;
            out_cnt    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_cnt   <= '0;
            last_rdata <= '0;
        end else begin
            pipe_v[0] <= accept;
            if (accept) pipe_d[0] <= mem[req_addr];
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            unique case ({accept, rsp_hs})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
            if (rsp_valid) last_rdata <= rsp_rdata;
        end
    end

    // Array storage carries no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (push) fifo_d[wr_ptr] <= tail_d;
        if (accept) begin
            for (int i = 0; i < NB; i++) begin
                if (req_we[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
            end
`ifdef DEBUG
            if (req_we != '0)
                $display("%0t [MEM W] addr=%h data=%h we=%b", $time, req_addr, req_wdata, req_we);
            else
                $display("%0t [MEM R] addr=%h data=%h we=%b", $time, req_addr, mem[req_addr], req_we);
`endif
        end
    end
endmodule
